// File: rtl/smc_lite_pkg.sv
// ---------------------------------------------------------------------------
// smc_lite_pkg
// Shared types and defaults for the lite static memory controller.
//   smc_wr_state_e  : write-strobe sequencer phase encoding
//   smc_wr_timing_t : setup / strobe / hold wait-state triple
//   SMC_CNT_W       : default width of a wait-state field (and of the timing struct fields)
//   SMC_LANES       : default number of byte lanes
// ---------------------------------------------------------------------------
package smc_lite_pkg;

  localparam int SMC_CNT_W = 4;
  localparam int SMC_LANES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } smc_wr_state_e;

  typedef struct packed {
    logic [SMC_CNT_W-1:0] setup;
    logic [SMC_CNT_W-1:0] pulse;
    logic [SMC_CNT_W-1:0] hold;
  } smc_wr_timing_t;

endpackage

// File: rtl/smc_wr_strobe_ctrl_lite.sv
// ---------------------------------------------------------------------------
// smc_wr_strobe_ctrl_lite
// Write-strobe sequencer: accepts one write at a time and steps it through
// setup, strobe and hold phases of programmable length, driving the lane
// enables and write strobe consumed by the write-enable gating stage.
//
// Ports
//   sys_clk      in   system clock, rising edge
//   n_sys_reset  in   synchronous active-low reset
//   wr_req       in   write request, accepted when wr_ready is high
//   wr_be        in   byte enables (active-high), sampled at accept
//   cfg_setup    in   setup wait states (0 allowed), sampled at accept
//   cfg_pulse    in   strobe width in cycles (0 behaves as 1), sampled at accept
//   cfg_hold     in   hold wait states (0 allowed), sampled at accept
//   wr_ready     out  high only while idle
//   wr_done      out  one-cycle pulse in the final busy cycle
//   n_r_we       out  lane enables, active-low, asserted for the whole transaction
//   n_r_wr       out  write strobe, active-low, asserted in the strobe phase
//   r_full       out  full-cycle qualifier, high in the strobe phase
//
// CNT_W must equal SMC_CNT_W because the timing fields travel in the shared
// package struct.
// ---------------------------------------------------------------------------
module smc_wr_strobe_ctrl_lite
  import smc_lite_pkg::*;
#(
  parameter int CNT_W = SMC_CNT_W,
  parameter int LANES = SMC_LANES
) (
  input  logic             sys_clk,
  input  logic             n_sys_reset,
  input  logic             wr_req,
  input  logic [LANES-1:0] wr_be,
  input  logic [CNT_W-1:0] cfg_setup,
  input  logic [CNT_W-1:0] cfg_pulse,
  input  logic [CNT_W-1:0] cfg_hold,
  output logic             wr_ready,
  output logic             wr_done,
  output logic [LANES-1:0] n_r_we,
  output logic             n_r_wr,
  output logic             r_full
);

  if (CNT_W != SMC_CNT_W) begin : g_cnt_w_check
    $error("smc_wr_strobe_ctrl_lite: CNT_W must equal SMC_CNT_W");
  end

  // Phase length L is loaded as L-1; callers guarantee L >= 1.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return len - CNT_W'(1);
  endfunction

  // Strobe width of 0 is promoted to a single cycle.
  function automatic logic [CNT_W-1:0] pulse_m1(input logic [CNT_W-1:0] pulse);
    return (pulse == '0) ? '0 : pulse - CNT_W'(1);
  endfunction

  smc_wr_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  smc_wr_timing_t   tm_in;
  logic [CNT_W-1:0] pulse_q, hold_q;
  logic [LANES-1:0] be_q;
  logic [LANES-1:0] be_eff;
  logic [CNT_W-1:0] hold_eff;
  logic             accept;

  logic [LANES-1:0] n_we_d, n_we_q;
  logic             n_wr_d, n_wr_q;
  logic             full_d, full_q;
  logic             done_d, done_q;
  logic             ready_q;

  assign tm_in  = '{setup: cfg_setup, pulse: cfg_pulse, hold: cfg_hold};
  assign accept = wr_req && (state_q == IDLE);

  // In the accept cycle the registered copies are not yet loaded, so the
  // output look-ahead uses the live inputs instead.
  assign be_eff   = accept ? wr_be    : be_q;
  assign hold_eff = accept ? cfg_hold : hold_q;

  // ---- stage boundary: next-state / next-output decode ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (tm_in.setup != '0) begin
            state_d = SETUP;
            cnt_d   = len_m1(tm_in.setup);
          end else begin
            state_d = STROBE;
            cnt_d   = pulse_m1(tm_in.pulse);
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = pulse_m1(pulse_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          if (hold_q != '0) begin
            state_d = HOLD;
            cnt_d   = len_m1(hold_q);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so every pin
  // comes straight from a flop and cannot glitch into the strobe gating.
  always_comb begin
    n_we_d = (state_d != IDLE) ? ~be_eff : '1;
    n_wr_d = (state_d != STROBE);
    full_d = (state_d == STROBE);
    // Final busy cycle: last count of HOLD, or of STROBE when there is no hold.
    done_d = (cnt_d == '0) &&
             ((state_d == HOLD) || ((state_d == STROBE) && (hold_eff == '0)));
  end

  // ---- stage boundary: control and output registers ----
  always_ff @(posedge sys_clk) begin
    if (!n_sys_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      n_we_q  <= '1;
      n_wr_q  <= 1'b1;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      n_we_q  <= n_we_d;
      n_wr_q  <= n_wr_d;
      full_q  <= full_d;
      done_q  <= done_d;
    end
  end

  // Transaction parameters. Setup is consumed directly into the counter at
  // accept, so only strobe width, hold and lane enables need holding.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      pulse_q <= tm_in.pulse;
      hold_q  <= tm_in.hold;
      be_q    <= wr_be;
    end
  end

  assign wr_ready = ready_q;
  assign wr_done  = done_q;
  assign n_r_we   = n_we_q;
  assign n_r_wr   = n_wr_q;
  assign r_full   = full_q;

endmodule

// File: tb/tb_smc_wr_strobe_ctrl_lite.sv
// ---------------------------------------------------------------------------
// tb_smc_wr_strobe_ctrl_lite
// Self-checking bench for smc_wr_strobe_ctrl_lite: a table of hand-derived
// transaction timings, hand-written multi-cycle sequences (back-to-back,
// reset mid-strobe) and randomized traffic against a waveform-list model.
// ---------------------------------------------------------------------------
module tb_smc_wr_strobe_ctrl_lite;
  import smc_lite_pkg::*;

  localparam int CNT_W = 4;
  localparam int LANES = 4;

  logic             sys_clk = 1'b0;
  logic             n_sys_reset = 1'b0;
  logic             wr_req = 1'b0;
  logic [LANES-1:0] wr_be = '0;
  logic [CNT_W-1:0] cfg_setup = '0;
  logic [CNT_W-1:0] cfg_pulse = '0;
  logic [CNT_W-1:0] cfg_hold = '0;
  logic             wr_ready;
  logic             wr_done;
  logic [LANES-1:0] n_r_we;
  logic             n_r_wr;
  logic             r_full;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  smc_wr_strobe_ctrl_lite #(.CNT_W(CNT_W), .LANES(LANES)) dut (
    .sys_clk     (sys_clk),
    .n_sys_reset (n_sys_reset),
    .wr_req      (wr_req),
    .wr_be       (wr_be),
    .cfg_setup   (cfg_setup),
    .cfg_pulse   (cfg_pulse),
    .cfg_hold    (cfg_hold),
    .wr_ready    (wr_ready),
    .wr_done     (wr_done),
    .n_r_we      (n_r_we),
    .n_r_wr      (n_r_wr),
    .r_full      (r_full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- table-driven transactions (expected timing derived by hand) ----
  typedef struct {
    logic [LANES-1:0] be;
    logic [CNT_W-1:0] s;
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] h;
    int               busy;       // busy cycles
    int               str_first;  // first strobe cycle, 1 = first busy cycle
    int               str_len;    // strobe cycles
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx, input vec_t v);
    logic [LANES-1:0] exp_we;
    logic             in_str;
    exp_we = ~v.be;
    wr_req    = 1'b1;
    wr_be     = v.be;
    cfg_setup = v.s;
    cfg_pulse = v.p;
    cfg_hold  = v.h;
    chk($sformatf("vec%0d ready_at_accept", idx), wr_ready, 1);
    @(posedge sys_clk); @(negedge sys_clk);
    // scramble inputs after accept: must not affect the transaction in flight
    wr_req    = 1'b0;
    wr_be     = ~v.be;
    cfg_setup = v.s + 4'd3;
    cfg_pulse = v.p + 4'd5;
    cfg_hold  = v.h + 4'd7;
    for (int k = 1; k <= v.busy + 1; k++) begin
      in_str = (k >= v.str_first) && (k < v.str_first + v.str_len);
      if (k <= v.busy) begin
        chk($sformatf("vec%0d c%0d n_r_we", idx, k), n_r_we, exp_we);
        chk($sformatf("vec%0d c%0d n_r_wr", idx, k), n_r_wr, !in_str);
        chk($sformatf("vec%0d c%0d r_full", idx, k), r_full, in_str);
        chk($sformatf("vec%0d c%0d wr_done", idx, k), wr_done, (k == v.busy));
        chk($sformatf("vec%0d c%0d wr_ready", idx, k), wr_ready, 0);
      end else begin
        chk($sformatf("vec%0d idle n_r_we", idx), n_r_we, 4'hF);
        chk($sformatf("vec%0d idle n_r_wr", idx), n_r_wr, 1);
        chk($sformatf("vec%0d idle r_full", idx), r_full, 0);
        chk($sformatf("vec%0d idle wr_done", idx), wr_done, 0);
        chk($sformatf("vec%0d idle wr_ready", idx), wr_ready, 1);
      end
      @(posedge sys_clk); @(negedge sys_clk);
    end
  endtask

  // ---- reference model: per-cycle expected waveform list ----
  typedef struct packed {
    logic [LANES-1:0] we;
    logic             wr;
    logic             full;
    logic             done;
  } exp_t;

  exp_t exp_q[$];

  function automatic void push_txn(input logic [LANES-1:0] be, input int s, input int p, input int h);
    int   pp;
    int   n;
    exp_t e;
    pp = (p == 0) ? 1 : p;
    n  = s + pp + h;
    for (int k = 0; k < n; k++) begin
      e.we   = ~be;
      e.full = (k >= s) && (k < s + pp);
      e.wr   = !e.full;
      e.done = (k == n - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Called at a negedge with this cycle's inputs already applied.
  task automatic step(input string tag);
    exp_t e;
    logic busy;
    busy = (exp_q.size() != 0);
    if (busy) e = exp_q.pop_front();
    else      e = '{we: '1, wr: 1'b1, full: 1'b0, done: 1'b0};
    chk({tag, " wr_ready"}, wr_ready, !busy);
    chk({tag, " n_r_we"},   n_r_we,   e.we);
    chk({tag, " n_r_wr"},   n_r_wr,   e.wr);
    chk({tag, " r_full"},   r_full,   e.full);
    chk({tag, " wr_done"},  wr_done,  e.done);
    if (!n_sys_reset) exp_q.delete();
    else if (!busy && wr_req) push_txn(wr_be, int'(cfg_setup), int'(cfg_pulse), int'(cfg_hold));
    @(posedge sys_clk); @(negedge sys_clk);
  endtask

  function automatic logic [CNT_W-1:0] rnd_cfg();
    if ($urandom_range(0, 7) == 0) return CNT_W'($urandom_range(0, 15));
    return CNT_W'($urandom_range(0, 3));
  endfunction

  initial begin
    vecs[0] = '{4'b0101, 4'd2, 4'd3, 4'd1,  6,  3,  3};
    vecs[1] = '{4'b1111, 4'd0, 4'd0, 4'd0,  1,  1,  1};
    vecs[2] = '{4'b0000, 4'd1, 4'd1, 4'd0,  2,  2,  1};
    vecs[3] = '{4'b1000, 4'd0, 4'd8, 4'd2, 10,  1,  8};
    vecs[4] = '{4'b0011, 4'd15, 4'd15, 4'd15, 45, 16, 15};
    vecs[5] = '{4'b1100, 4'd3, 4'd0, 4'd0,  4,  4,  1};
    vecs[6] = '{4'b0110, 4'd0, 4'd2, 4'd4,  6,  1,  2};

    // reset held for 3 cycles
    n_sys_reset = 1'b0;
    wr_req      = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset n_r_we",   n_r_we,   4'hF);
    chk("reset n_r_wr",   n_r_wr,   1);
    chk("reset r_full",   r_full,   0);
    chk("reset wr_ready", wr_ready, 1);
    chk("reset wr_done",  wr_done,  0);
    wr_req      = 1'b0;
    n_sys_reset = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // back-to-back with wr_req held high, timing 1/1/0
    wr_req    = 1'b1;
    wr_be     = 4'b1001;
    cfg_setup = 4'd1;
    cfg_pulse = 4'd1;
    cfg_hold  = 4'd0;
    repeat (9) step("b2b");
    wr_req = 1'b0;
    repeat (2) step("b2b_tail");

    // reset asserted during the strobe of a 0/8/2 transaction
    wr_req    = 1'b1;
    wr_be     = 4'b1111;
    cfg_setup = 4'd0;
    cfg_pulse = 4'd8;
    cfg_hold  = 4'd2;
    step("abort_accept");
    wr_req = 1'b0;
    repeat (3) step("abort_strobe");
    n_sys_reset = 1'b0;
    step("abort_rst");
    n_sys_reset = 1'b1;
    step("abort_idle");
    step("abort_idle2");
    wr_req    = 1'b1;
    wr_be     = 4'b0101;
    cfg_setup = 4'd2;
    cfg_pulse = 4'd3;
    cfg_hold  = 4'd1;
    step("after_abort_accept");
    wr_req = 1'b0;
    repeat (8) step("after_abort");

    // randomized traffic, inputs change every cycle, occasional resets
    repeat (400) begin
      wr_req      = 1'($urandom_range(0, 1));
      wr_be       = LANES'($urandom);
      cfg_setup   = rnd_cfg();
      cfg_pulse   = rnd_cfg();
      cfg_hold    = rnd_cfg();
      n_sys_reset = ($urandom_range(0, 60) != 0);
      step("rnd");
    end
    n_sys_reset = 1'b1;
    wr_req      = 1'b0;
    repeat (50) step("drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
